whack_mole_round_ctrl: RTL and testbench



---
 rtl/whack_mole_round_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_whack_mole_round_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/whack_mole_round_ctrl.sv
// Round sequencer for the whack-a-mole game: shows one mole per round, judges
// the key press against a level-dependent window, and keeps score, level and misses.
module whack_mole_round_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int WIN0_MS  = 2000,
  parameter int WIN1_MS  = 1500,
  parameter int WIN2_MS  = 1000,
  parameter int WIN3_MS  = 500,
  parameter int FB_MS    = 200,
  parameter int GAP_MS   = 300,
  parameter int LV_STEP  = 5,
  parameter int MAX_MISS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  input  logic [2:0] rand_pos,
  output logic [7:0] mole_led,
  output logic       buzzer,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [7:0] score,
  output logic [1:0] level,
  output logic       game_over
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MW = (MAX_MISS > 0) ? $clog2(MAX_MISS + 1) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SHOW = 3'd2,
    HIT  = 3'd3,
    MISS = 3'd4,
    GAP  = 3'd5,
    OVER = 3'd6
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [PW-1:0]   presc;
  logic            tick;
  logic [11:0]     timer;
  logic [11:0]     win;
  logic [2:0]      pos;
  logic [MW-1:0]   misses;
  logic [7:0]      score_inc;
  logic            lvl_up;
  logic            win_done;
  logic            fb_done;
  logic            gap_done;
  logic            key_real;
  logic            scored;
  logic            missed;
  logic            new_game;

  function automatic logic [11:0] win_for(input logic [1:0] lv);
    logic [11:0] w;
    case (lv)
      2'd0:    w = 12'(WIN0_MS);
      2'd1:    w = 12'(WIN1_MS);
      2'd2:    w = 12'(WIN2_MS);
      default: w = 12'(WIN3_MS);
    endcase
    return w;
  endfunction

  assign tick      = (presc == PW'(TICK_DIV - 1));
  // A phase ends on the tick that would take its timer to the full duration.
  assign win_done  = tick && (timer == (win - 12'd1));
  assign fb_done   = tick && (timer == 12'(FB_MS - 1));
  assign gap_done  = tick && (timer == 12'(GAP_MS - 1));
  assign key_real  = key_valid && (key_code < 5'd16);
  assign score_inc = (score == 8'hFF) ? 8'hFF : (score + 8'd1);
  assign lvl_up    = ((score_inc % 8'(LV_STEP)) == 8'd0) && (score_inc != 8'd0) && (level != 2'd3);
  assign scored    = (state == SHOW) && (next_state == HIT);
  assign missed    = (state == SHOW) && (next_state == MISS);
  assign new_game  = ((state == IDLE) || (state == OVER)) && (next_state == LOAD);

  // Free-running 1 ms prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Next-state decode; a real key press in SHOW takes priority over the timeout.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = LOAD;
        else       next_state = IDLE;
      end
      LOAD: next_state = SHOW;
      SHOW: begin
        if (key_real) begin
          if (key_code == {2'b00, pos}) next_state = HIT;
          else                          next_state = MISS;
        end else if (win_done) begin
          next_state = MISS;
        end else begin
          next_state = SHOW;
        end
      end
      HIT: begin
        if (fb_done) next_state = GAP;
        else         next_state = HIT;
      end
      MISS: begin
        if (fb_done) begin
          if (misses == MW'(MAX_MISS)) next_state = OVER;
          else                         next_state = GAP;
        end else begin
          next_state = MISS;
        end
      end
      GAP: begin
        if (gap_done) next_state = LOAD;
        else          next_state = GAP;
      end
      OVER: begin
        if (start) next_state = LOAD;
        else       next_state = OVER;
      end
      default: next_state = IDLE;
    endcase
  end

  // State, phase timer, round bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= 12'd0;
      win        <= 12'd0;
      pos        <= 3'd0;
      misses     <= '0;
      score      <= 8'd0;
      level      <= 2'd0;
      mole_led   <= 8'h00;
      buzzer     <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= next_state;
      timer      <= (next_state != state) ? 12'd0 : (timer + {11'd0, tick});
      hit_pulse  <= scored;
      miss_pulse <= missed;
      buzzer     <= (next_state == HIT);
      game_over  <= (next_state == OVER);

      if (state == LOAD) begin
        pos <= rand_pos;
        win <= win_for(level);
      end

      case (next_state)
        SHOW: begin
          if (state == LOAD) mole_led <= 8'd1 << rand_pos;
          else               mole_led <= mole_led;
        end
        OVER:    mole_led <= 8'hFF;
        default: mole_led <= 8'h00;
      endcase

      if (new_game) begin
        score  <= 8'd0;
        level  <= 2'd0;
        misses <= '0;
      end else if (scored) begin
        score <= score_inc;
        if (lvl_up) level <= level + 2'd1;
      end else if (missed) begin
        misses <= misses + MW'(1);
      end
    end
  end

endmodule

// File: tb/tb_whack_mole_round_ctrl.sv
// Directed bench for whack_mole_round_ctrl using shortened timing parameters.
module tb_whack_mole_round_ctrl;

  localparam int TD  = 4;
  localparam int FB  = 2;
  localparam int GP  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       key_valid;
  logic [4:0] key_code;
  logic [2:0] rand_pos;
  logic [7:0] mole_led;
  logic       buzzer;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [7:0] score;
  logic [1:0] level;
  logic       game_over;

  int n_checks = 0;
  int n_err    = 0;
  int cyc;

  typedef struct {
    logic [2:0] pos;
    logic [4:0] key;
    logic       exp_hit;
    logic [7:0] exp_score;
    logic [1:0] exp_level;
    logic       exp_over;
  } vec_t;

  vec_t tbl [8];

  whack_mole_round_ctrl #(
    .TICK_DIV(TD), .WIN0_MS(10), .WIN1_MS(8), .WIN2_MS(6), .WIN3_MS(4),
    .FB_MS(FB), .GAP_MS(GP), .LV_STEP(5), .MAX_MISS(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_valid(key_valid),
    .key_code(key_code), .rand_pos(rand_pos), .mole_led(mole_led),
    .buzzer(buzzer), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .score(score), .level(level), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Bench copy of the free-running ms prescaler phase: posedges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int win_of(input logic [1:0] lv);
    case (lv)
      2'd0:    return 10;
      2'd1:    return 8;
      2'd2:    return 6;
      default: return 4;
    endcase
  endfunction

  // Cycles from a state entry at posedge e until a phase of ms ticks ends.
  function automatic int exp_dur(input int e, input int ms);
    int t1;
    t1 = e + (TD - (e % TD));
    return t1 + TD * (ms - 1) - e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic press(input logic [4:0] code);
    key_valid = 1'b1;
    key_code  = code;
    step();
    key_valid = 1'b0;
    key_code  = 5'd16;
  endtask

  task automatic wait_show(output int e, output int n);
    n = 0;
    while (!$onehot(mole_led) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) chk("wait_show timeout", 32'd1, 32'd0);
    e = cyc;
  endtask

  task automatic do_hit(input logic [2:0] p, input logic [4:0] k, input logic [2:0] nxt,
                        input logic [7:0] es, input logic [1:0] el, output int e_next);
    int e, n, cnt, g;
    wait_show(e, n);
    chk("hit mole_led", {24'd0, mole_led}, 32'd1 << p);
    step();
    while ((cyc % TD) != TD - 1) step();
    press(k);
    chk("hit_pulse", {31'd0, hit_pulse}, 32'd1);
    chk("hit no miss_pulse", {31'd0, miss_pulse}, 32'd0);
    chk("hit score", {24'd0, score}, {24'd0, es});
    chk("hit level", {30'd0, level}, {30'd0, el});
    chk("hit mole off", {24'd0, mole_led}, 32'd0);
    rand_pos = nxt;
    cnt = 1;
    step();
    chk("hit_pulse one cycle", {31'd0, hit_pulse}, 32'd0);
    while (buzzer && cnt < 50) begin
      cnt++;
      step();
    end
    chk("buzzer length", cnt, FB * TD);
    g = cyc;
    wait_show(e_next, n);
    chk("gap length", n, exp_dur(g, GP) + 1);
  endtask

  task automatic do_miss(input logic [2:0] p, input logic [4:0] k, input logic [2:0] nxt,
                         input logic [7:0] es, input logic [1:0] el, input logic eo,
                         input int win);
    int e, n, m;
    wait_show(e, n);
    chk("miss mole_led", {24'd0, mole_led}, 32'd1 << p);
    step();
    step();
    if (k == 5'd16) begin
      press(5'd16);
      chk("code16 no hit", {31'd0, hit_pulse}, 32'd0);
      chk("code16 no miss", {31'd0, miss_pulse}, 32'd0);
      n = 0;
      while (!miss_pulse && n < 400) begin
        step();
        n++;
      end
      chk("timeout latency", cyc - e, exp_dur(e, win));
    end else begin
      press(k);
    end
    chk("miss_pulse", {31'd0, miss_pulse}, 32'd1);
    chk("miss no hit_pulse", {31'd0, hit_pulse}, 32'd0);
    chk("miss score", {24'd0, score}, {24'd0, es});
    chk("miss level", {30'd0, level}, {30'd0, el});
    chk("miss mole off", {24'd0, mole_led}, 32'd0);
    chk("miss buzzer", {31'd0, buzzer}, 32'd0);
    rand_pos = nxt;
    m = cyc;
    repeat (exp_dur(m, FB)) step();
    chk("game_over after miss", {31'd0, game_over}, {31'd0, eo});
    if (eo) chk("over leds", {24'd0, mole_led}, 32'hFF);
  endtask

  initial begin
    int e, n, t, g;
    logic [1:0] prev_lv;
    logic [2:0] nxt;

    tbl[0] = '{3'd3, 5'd3,  1'b1, 8'd1, 2'd0, 1'b0};
    tbl[1] = '{3'd5, 5'd2,  1'b0, 8'd1, 2'd0, 1'b0};
    tbl[2] = '{3'd1, 5'd16, 1'b0, 8'd1, 2'd0, 1'b0};
    tbl[3] = '{3'd0, 5'd0,  1'b1, 8'd2, 2'd0, 1'b0};
    tbl[4] = '{3'd7, 5'd7,  1'b1, 8'd3, 2'd0, 1'b0};
    tbl[5] = '{3'd2, 5'd2,  1'b1, 8'd4, 2'd0, 1'b0};
    tbl[6] = '{3'd6, 5'd6,  1'b1, 8'd5, 2'd1, 1'b0};
    tbl[7] = '{3'd4, 5'd16, 1'b0, 8'd5, 2'd1, 1'b1};

    rst_n = 1'b0; start = 1'b0; key_valid = 1'b0; key_code = 5'd16; rand_pos = 3'd3;
    #23 rst_n = 1'b1;
    step();
    chk("reset mole_led", {24'd0, mole_led}, 32'd0);
    chk("reset score", {24'd0, score}, 32'd0);
    chk("reset level", {30'd0, level}, 32'd0);
    chk("reset buzzer", {31'd0, buzzer}, 32'd0);
    chk("reset game_over", {31'd0, game_over}, 32'd0);
    press(5'd3);
    chk("idle key ignored", {30'd0, hit_pulse, miss_pulse}, 32'd0);

    start = 1'b1;
    step();
    start = 1'b0;
    chk("load mole dark", {24'd0, mole_led}, 32'd0);
    step();
    chk("start to mole 2 cycles", {24'd0, mole_led}, 32'h08);

    for (int i = 0; i < 8; i++) begin
      nxt     = (i < 7) ? tbl[i+1].pos : 3'd2;
      prev_lv = (i == 0) ? 2'd0 : tbl[i-1].exp_level;
      if (tbl[i].exp_hit)
        do_hit(tbl[i].pos, tbl[i].key, nxt, tbl[i].exp_score, tbl[i].exp_level, e);
      else
        do_miss(tbl[i].pos, tbl[i].key, nxt, tbl[i].exp_score, tbl[i].exp_level,
                tbl[i].exp_over, win_of(prev_lv));
    end

    press(5'd4);
    chk("over key no pulse", {30'd0, hit_pulse, miss_pulse}, 32'd0);
    chk("over stays", {31'd0, game_over}, 32'd1);
    chk("over score held", {24'd0, score}, 32'd5);
    rand_pos = 3'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart score", {24'd0, score}, 32'd0);
    chk("restart level", {30'd0, level}, 32'd0);
    chk("restart game_over", {31'd0, game_over}, 32'd0);
    step();
    chk("restart mole", {24'd0, mole_led}, 32'h04);

    for (int k = 0; k < 20; k++) begin
      do_hit(3'((k + 2) % 8), 5'((k + 2) % 8), 3'((k + 3) % 8), 8'(k + 1),
             2'(((k + 1) / 5 > 3) ? 3 : (k + 1) / 5), e);
    end

    t = e + exp_dur(e, 4);
    n = 0;
    while (cyc < t - 1 && n < 100) begin
      step();
      n++;
    end
    rand_pos = 3'd1;
    press(5'd6);
    chk("key beats timeout hit", {31'd0, hit_pulse}, 32'd1);
    chk("key beats timeout miss", {31'd0, miss_pulse}, 32'd0);
    chk("score 21", {24'd0, score}, 32'd21);
    chk("level saturated", {30'd0, level}, 32'd3);

    wait_show(e, n);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async reset mole", {24'd0, mole_led}, 32'd0);
    chk("async reset score", {24'd0, score}, 32'd0);
    chk("async reset level", {30'd0, level}, 32'd0);
    chk("async reset flags", {28'd0, buzzer, hit_pulse, miss_pulse, game_over}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    g = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mole_led != 8'h00) g++;
    end
    chk("idle after reset dark", g, 0);
    rand_pos = 3'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("start after reset", {24'd0, mole_led}, 32'h20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
